// File: rtl/pc_fetch_if.sv
// Fetch/redirect bundle between the PC fetch unit, instruction memory and the
// redirect sources (control unit / ALU).
interface pc_fetch_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             halt;
    logic             resume;
    logic             PCsrc;
    logic [WIDTH-1:0] ImmOp;
    logic             jalr_en;
    logic [WIDTH-1:0] jalr_target;
    logic             trap_req;
    logic             fetch_ready;
    logic [WIDTH-1:0] PC;
    logic             fetch_valid;
    logic [WIDTH-1:0] fetch_count;
    logic             misalign;
    logic [WIDTH-1:0] misalign_addr;

    modport master (
        input  stall, halt, resume, PCsrc, ImmOp, jalr_en, jalr_target,
               trap_req, fetch_ready,
        output PC, fetch_valid, fetch_count, misalign, misalign_addr
    );

    modport slave (
        output stall, halt, resume, PCsrc, ImmOp, jalr_en, jalr_target,
               trap_req, fetch_ready,
        input  PC, fetch_valid, fetch_count, misalign, misalign_addr
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and fetch-request generator with prioritised redirects,
// stall/halt control and an accepted-fetch counter. Optional target alignment
// checking is enabled by defining PC_ALIGN_CHECK_EN.
module pc_fetch_unit #(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] INC      = WIDTH'(32'd4),
    parameter logic [31:0]      TRAP_VEC = 32'h0000_0100
) (
    input  logic       clk,
    input  logic       rst,
    pc_fetch_if.master bus
);
    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_e;

    localparam logic [WIDTH-1:0] TRAP_PC    = WIDTH'(TRAP_VEC);
    localparam logic [WIDTH-1:0] JALR_MASK  = {{(WIDTH-1){1'b1}}, 1'b0};
    localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             fetch_valid_s;
    logic             accept_s;
    logic             redir_s;
    logic [WIDTH-1:0] tgt_s;

    assign accept_s = fetch_valid_s & bus.fetch_ready;

    // Redirect selection; BOOT ignores every redirect input
    always_comb begin
        redir_s = 1'b0;
        tgt_s   = pc_q;
        if (state_q == S_BOOT) begin
            redir_s = 1'b0;
        end else if (bus.trap_req) begin
            redir_s = 1'b1;
            tgt_s   = TRAP_PC;
        end else if (bus.jalr_en) begin
            redir_s = 1'b1;
            tgt_s   = bus.jalr_target & JALR_MASK;
        end else if (bus.PCsrc) begin
            redir_s = 1'b1;
            tgt_s   = pc_q + bus.ImmOp;
        end else begin
            redir_s = 1'b0;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    logic             bad_s;
    logic             mis_q, mis_d;
    logic [WIDTH-1:0] mis_addr_q, mis_addr_d;

    // Trap targets are trusted; only jalr/branch targets are checked
    assign bad_s = redir_s & ~bus.trap_req & (tgt_s[1:0] != 2'b00);
`endif

    // Next PC and fetch counter
    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        if (redir_s) begin
`ifdef PC_ALIGN_CHECK_EN
            pc_d = bad_s ? TRAP_PC : tgt_s;
`else
            pc_d = tgt_s;
`endif
        end else if (bus.stall) begin
            pc_d = pc_q;
        end else if (accept_s) begin
            pc_d = pc_q + INC;
        end else begin
            pc_d = pc_q;
        end
        if (accept_s) begin
            cnt_d = cnt_q + ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // FSM next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN: begin
                if (bus.halt && !redir_s) begin
                    state_d = S_HALT;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_HALT: begin
                if (bus.trap_req) begin
                    state_d = S_RUN;
                end else if (bus.resume && !bus.halt) begin
                    state_d = S_RUN;
                end else begin
                    state_d = S_HALT;
                end
            end
            default: state_d = S_BOOT;
        endcase
    end

    // FSM outputs decoded from registered state
    always_comb begin
        fetch_valid_s = 1'b0;
        case (state_q)
            S_RUN:   fetch_valid_s = 1'b1;
            default: fetch_valid_s = 1'b0;
        endcase
    end

    // State, PC and counter registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
            cnt_q   <= {WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    assign mis_d      = bad_s;
    assign mis_addr_d = bad_s ? tgt_s : mis_addr_q;

    // Misalignment pulse and sticky offending address
    always_ff @(posedge clk) begin
        if (!rst) begin
            mis_q      <= 1'b0;
            mis_addr_q <= {WIDTH{1'b0}};
        end else begin
            mis_q      <= mis_d;
            mis_addr_q <= mis_addr_d;
        end
    end

    assign bus.misalign      = mis_q;
    assign bus.misalign_addr = mis_addr_q;
`else
    assign bus.misalign      = 1'b0;
    assign bus.misalign_addr = {WIDTH{1'b0}};
`endif

    assign bus.PC          = pc_q;
    assign bus.fetch_valid = fetch_valid_s;
    assign bus.fetch_count = cnt_q;
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: a default-reset instance plus a second
// instance with RESET_PC near the top of the address space for wrap checks.
module tb_pc_fetch_unit;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   nchk = 0;
    int   nerr = 0;

    always #5 clk = ~clk;

    pc_fetch_if #(.WIDTH(32)) b ();
    pc_fetch_if #(.WIDTH(32)) w ();

    pc_fetch_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (b)
    );

    pc_fetch_unit #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_w (
        .clk (clk),
        .rst (rst),
        .bus (w)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        b.stall = 1'b0; b.halt = 1'b0; b.resume = 1'b0; b.PCsrc = 1'b0;
        b.ImmOp = 32'h0; b.jalr_en = 1'b0; b.jalr_target = 32'h0;
        b.trap_req = 1'b0; b.fetch_ready = 1'b0;
        w.stall = 1'b0; w.halt = 1'b0; w.resume = 1'b0; w.PCsrc = 1'b0;
        w.ImmOp = 32'h0; w.jalr_en = 1'b0; w.jalr_target = 32'h0;
        w.trap_req = 1'b0; w.fetch_ready = 1'b0;

        step();
        step();
        chk("rst_pc", b.PC, 32'h0);
        chk("rst_fv", {31'd0, b.fetch_valid}, 32'd0);
        chk("rst_cnt", b.fetch_count, 32'd0);
        chk("rst_mis", {31'd0, b.misalign}, 32'd0);
        chk("rst_maddr", b.misalign_addr, 32'h0);
        chk("rst_pc_w", w.PC, 32'hFFFF_FFFC);

        // BOOT cycle: ready high but no accept yet
        rst = 1'b1; b.fetch_ready = 1'b1; w.fetch_ready = 1'b1;
        step();
        chk("boot_fv", {31'd0, b.fetch_valid}, 32'd1);
        chk("boot_pc", b.PC, 32'h0);
        chk("boot_cnt", b.fetch_count, 32'd0);

        step();
        chk("seq_pc4", b.PC, 32'h4);
        chk("seq_cnt1", b.fetch_count, 32'd1);
        chk("wrap_inc", w.PC, 32'h0);
        w.fetch_ready = 1'b0; w.PCsrc = 1'b1; w.ImmOp = 32'hFFFF_FFFC;

        step();
        chk("seq_pc8", b.PC, 32'h8);
        chk("seq_cnt2", b.fetch_count, 32'd2);
        chk("neg_branch", w.PC, 32'hFFFF_FFFC);
        w.ImmOp = 32'h8;
        b.fetch_ready = 1'b0;

        step();
        chk("wrap_branch", w.PC, 32'h4);
        w.PCsrc = 1'b0;
        step();
        step();
        chk("bp_pc", b.PC, 32'h8);
        chk("bp_cnt", b.fetch_count, 32'd2);
        chk("bp_fv", {31'd0, b.fetch_valid}, 32'd1);

        b.stall = 1'b1; b.fetch_ready = 1'b1;
        step();
        chk("stall_pc", b.PC, 32'h8);
        chk("stall_cnt", b.fetch_count, 32'd3);
        b.stall = 1'b0;

        step();
        chk("seq_pcC", b.PC, 32'hC);
        chk("seq_cnt4", b.fetch_count, 32'd4);

        // Priority: reach 0x40 then fire all redirects together
        b.fetch_ready = 1'b0; b.jalr_en = 1'b1; b.jalr_target = 32'h41;
        step();
        chk("jalr_bit0", b.PC, 32'h40);
        b.trap_req = 1'b1; b.jalr_target = 32'h201; b.PCsrc = 1'b1; b.ImmOp = 32'hFFFF_FFF8;
        step();
        chk("prio_trap", b.PC, 32'h100);
        b.trap_req = 1'b0;
        step();
        chk("prio_jalr", b.PC, 32'h200);
        b.jalr_en = 1'b0;
        step();
        chk("prio_branch", b.PC, 32'h1F8);
        chk("prio_fv", {31'd0, b.fetch_valid}, 32'd1);
        b.PCsrc = 1'b0;

        // Halt / resume
        b.jalr_en = 1'b1; b.jalr_target = 32'h10;
        step();
        chk("halt_setup", b.PC, 32'h10);
        b.jalr_en = 1'b0; b.halt = 1'b1;
        step();
        chk("halt_fv", {31'd0, b.fetch_valid}, 32'd0);
        chk("halt_pc", b.PC, 32'h10);
        b.halt = 1'b0; b.fetch_ready = 1'b1;
        step();
        chk("halt_hold_pc", b.PC, 32'h10);
        chk("halt_hold_cnt", b.fetch_count, 32'd4);
        b.halt = 1'b1; b.resume = 1'b1;
        step();
        chk("halt_and_resume", {31'd0, b.fetch_valid}, 32'd0);
        b.halt = 1'b0; b.fetch_ready = 1'b0;
        step();
        chk("resume_fv", {31'd0, b.fetch_valid}, 32'd1);
        chk("resume_pc", b.PC, 32'h10);
        b.resume = 1'b0; b.halt = 1'b1;
        step();
        chk("halt2_fv", {31'd0, b.fetch_valid}, 32'd0);
        b.halt = 1'b0; b.trap_req = 1'b1;
        step();
        chk("halt_trap_pc", b.PC, 32'h100);
        chk("halt_trap_fv", {31'd0, b.fetch_valid}, 32'd1);
        chk("halt_trap_cnt", b.fetch_count, 32'd4);
        b.trap_req = 1'b0;

        // Misaligned branch target
        b.jalr_en = 1'b1; b.jalr_target = 32'h20;
        step();
        chk("align_setup", b.PC, 32'h20);
        b.jalr_en = 1'b0; b.PCsrc = 1'b1; b.ImmOp = 32'h2;
        step();
`ifdef PC_ALIGN_CHECK_EN
        chk("mis_pc", b.PC, 32'h100);
        chk("mis_pulse", {31'd0, b.misalign}, 32'd1);
        chk("mis_addr", b.misalign_addr, 32'h22);
`else
        chk("mis_pc", b.PC, 32'h22);
        chk("mis_pulse", {31'd0, b.misalign}, 32'd0);
        chk("mis_addr", b.misalign_addr, 32'h0);
`endif
        b.PCsrc = 1'b0;
        step();
        chk("mis_pulse_end", {31'd0, b.misalign}, 32'd0);
`ifdef PC_ALIGN_CHECK_EN
        chk("mis_addr_hold", b.misalign_addr, 32'h22);
`else
        chk("mis_addr_hold", b.misalign_addr, 32'h0);
`endif

        // Reset mid-operation overrides a trap and an accept
        rst = 1'b0; b.trap_req = 1'b1; b.fetch_ready = 1'b1;
        step();
        chk("mid_rst_pc", b.PC, 32'h0);
        chk("mid_rst_fv", {31'd0, b.fetch_valid}, 32'd0);
        chk("mid_rst_cnt", b.fetch_count, 32'd0);
        chk("mid_rst_pc_w", w.PC, 32'hFFFF_FFFC);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
